// File: rtl/config_chain_loader.sv
// Serial loader for a ConfigCell configuration chain: shifts CHAIN_BITS bits from
// 32-bit words into the chain head while collecting the displaced tail bits as readback words.
module config_chain_loader #(
    parameter int CHAIN_BITS = 96,
    parameter int WORD_W     = 32
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ConfigOut,
    output logic              Config_Shift_En,
    input  logic              ConfigIn,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int REM_W = $clog2(CHAIN_BITS + 1);
    localparam int K_W   = $clog2(WORD_W + 1);
    localparam int CNT_W = (REM_W > K_W) ? REM_W : K_W;
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] acc_s;
    logic [IDX_W-1:0]  rb_idx_q, rb_idx_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;
    logic              busy_q, ready_q, shift_q, done_q;

    // Next-state logic for the load FSM, shift datapath and readback accumulator
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        k_d        = k_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        acc_s      = acc_q;
        rb_idx_d   = rb_idx_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    rem_d   = CNT_W'(CHAIN_BITS);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    sreg_d  = word_data;
                    k_d     = (rem_q > CNT_W'(WORD_W)) ? CNT_W'(WORD_W) : rem_q;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                rem_d = rem_q - CNT_W'(1);
                k_d   = k_q - CNT_W'(1);
                // The final bit of a word stays in sreg so ConfigOut holds its last value
                if (k_q > CNT_W'(1)) begin
                    sreg_d = sreg_q >> 1;
                end else begin
                    sreg_d = sreg_q;
                end
                acc_s[rb_idx_q] = ConfigIn;
                if ((rb_idx_q == IDX_W'(WORD_W - 1)) || (rem_q == CNT_W'(1))) begin
                    rb_data_d  = acc_s;
                    rb_valid_d = 1'b1;
                    acc_d      = '0;
                    rb_idx_d   = '0;
                end else begin
                    acc_d    = acc_s;
                    rb_idx_d = rb_idx_q + IDX_W'(1);
                end
                if (k_q == CNT_W'(1)) begin
                    state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_LOAD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge Config_Clock) begin
        if (Config_Reset) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            k_q        <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            rb_idx_q   <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            shift_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            k_q        <= k_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            rb_idx_q   <= rb_idx_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
            busy_q     <= (state_d != ST_IDLE);
            ready_q    <= (state_d == ST_LOAD);
            shift_q    <= (state_d == ST_SHIFT);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign word_ready      = ready_q;
    assign Config_Shift_En = shift_q;
    assign ConfigOut       = sreg_q[0];
    assign rb_data         = rb_data_q;
    assign rb_valid        = rb_valid_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Randomized scoreboard bench for config_chain_loader with behavioural chain models
// (40-bit main build plus 32-bit and 1-bit builds).
module tb_config_chain_loader;

    localparam int N = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        wvalid = 1'b0;
    logic        wready, cout, sen, cin, rbv, busy, done;
    logic [31:0] rbd;

    logic        s_start = 1'b0;
    logic [31:0] s_wdata = 32'd0;
    logic        s_wvalid = 1'b0;
    logic        wready32, cout32, sen32, rbv32, busy32, done32;
    logic        wready1, cout1, sen1, rbv1, busy1, done1;
    logic [31:0] rbd32, rbd1;

    config_chain_loader #(.CHAIN_BITS(N), .WORD_W(32)) dut (
        .Config_Clock(clk), .Config_Reset(rst), .start(start), .word_data(wdata),
        .word_valid(wvalid), .word_ready(wready), .ConfigOut(cout), .Config_Shift_En(sen),
        .ConfigIn(cin), .rb_data(rbd), .rb_valid(rbv), .busy(busy), .done(done));

    logic [31:0] chain32 = 32'd0;
    logic        chain1 = 1'b0;

    config_chain_loader #(.CHAIN_BITS(32), .WORD_W(32)) dut32 (
        .Config_Clock(clk), .Config_Reset(rst), .start(s_start), .word_data(s_wdata),
        .word_valid(s_wvalid), .word_ready(wready32), .ConfigOut(cout32), .Config_Shift_En(sen32),
        .ConfigIn(chain32[0]), .rb_data(rbd32), .rb_valid(rbv32), .busy(busy32), .done(done32));

    config_chain_loader #(.CHAIN_BITS(1), .WORD_W(32)) dut1 (
        .Config_Clock(clk), .Config_Reset(rst), .start(s_start), .word_data(s_wdata),
        .word_valid(s_wvalid), .word_ready(wready1), .ConfigOut(cout1), .Config_Shift_En(sen1),
        .ConfigIn(chain1), .rb_data(rbd1), .rb_valid(rbv1), .busy(busy1), .done(done1));

    // Physical chain models: head takes ConfigOut, tail drives ConfigIn
    logic [N-1:0] chain = '0;
    int shift_total = 0;
    assign cin = chain[0];
    always @(posedge clk) begin
        if (sen) begin
            chain       <= {cout, chain[N-1:1]};
            shift_total <= shift_total + 1;
        end
        if (sen32) chain32 <= {cout32, chain32[31:1]};
        if (sen1)  chain1  <= cout1;
    end

    int vec_cnt = 0;
    int err_cnt = 0;
    int done_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_w;
    logic [N-1:0] ref_chain = '0;
    logic [31:0] ref32 = 32'd0;
    logic        ref1 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the main build's readback and done pulses
    always @(negedge clk) begin
        if (rbv) begin
            if (exp_q.size() == 0) begin
                check("rb_unexpected", 64'd1, 64'd0);
            end else begin
                mon_w = exp_q.pop_front();
                check("rb_data", {32'd0, rbd}, {32'd0, mon_w});
            end
        end
        if (done) begin
            done_total++;
            check("rb_valid_with_done", {63'd0, rbv}, 64'd1);
        end
    end

    task automatic send_word(input logic [31:0] w, input int gap, input bit spam);
        int b = 0;
        while (!wready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!wready) check("ready_timeout", 64'd0, 64'd1);
        for (int g = 0; g < gap; g++) begin
            check("gap_shift_en", {63'd0, sen}, 64'd0);
            check("gap_ready", {63'd0, wready}, 64'd1);
            if (spam && g == 0) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wdata  = w;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        wdata  = $urandom;
    endtask

    task automatic do_load(input logic [31:0] w0, input logic [31:0] w1, input int gap, input bit spam);
        int s0, d0, b;
        exp_q.push_back(ref_chain[31:0]);
        exp_q.push_back({24'd0, ref_chain[39:32]});
        ref_chain = {w1[7:0], w0};
        s0 = shift_total;
        d0 = done_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word(w0, 0, 1'b0);
        send_word(w1, gap, spam);
        b = 0;
        while (!done && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
        if (spam) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("shift_cycles", 64'(shift_total - s0), 64'd40);
        check("done_count", 64'(done_total - d0), 64'd1);
        check("chain_content", 64'(chain), 64'(ref_chain));
        check("rb_words_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic small_load(input logic [31:0] w);
        logic [31:0] e32, e1;
        int n32 = 0, n1 = 0;
        e32 = ref32;
        e1  = {31'd0, ref1};
        ref32 = w;
        ref1  = w[0];
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check("ready32", {63'd0, wready32}, 64'd1);
        check("ready1", {63'd0, wready1}, 64'd1);
        s_wdata  = w;
        s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done32) begin
                n32++;
                check("rbv32_with_done", {63'd0, rbv32}, 64'd1);
                check("rbd32", {32'd0, rbd32}, {32'd0, e32});
            end else if (rbv32) begin
                check("rbv32_without_done", 64'd1, 64'd0);
            end
            if (done1) begin
                n1++;
                check("rbv1_with_done", {63'd0, rbv1}, 64'd1);
                check("rbd1", {32'd0, rbd1}, {32'd0, e1});
            end else if (rbv1) begin
                check("rbv1_without_done", 64'd1, 64'd0);
            end
        end
        check("done32_count", 64'(n32), 64'd1);
        check("done1_count", 64'(n1), 64'd1);
        check("chain32", {32'd0, chain32}, {32'd0, ref32});
        check("chain1", {63'd0, chain1}, {63'd0, ref1});
        check("busy_small", {62'd0, busy32, busy1}, 64'd0);
    endtask

    initial begin
        int s0, d0, b;
        logic [31:0] w0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, wready}, 64'd0);
        check("rst_shift_en", {63'd0, sen}, 64'd0);
        check("rst_done_rbv", {62'd0, done, rbv}, 64'd0);
        check("rst_rb_data_cout", {31'd0, rbd, cout}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_load(32'hDEADBEEF, 32'h000000A5, 0, 1'b0);
        check("s1_chain", 64'(chain), 64'h000000A5DEADBEEF);
        do_load(32'h12345678, 32'hFFFFFF3C, 0, 1'b0);
        check("s2_chain", 64'(chain), 64'h0000003C12345678);
        do_load(32'hDEADBEEF, 32'h000000A5, 5, 1'b0);
        check("s3_chain", 64'(chain), 64'h000000A5DEADBEEF);
        do_load($urandom, $urandom, 2, 1'b1);

        // Abort after exactly ten shifted bits
        w0 = $urandom;
        s0 = shift_total;
        d0 = done_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word(w0, 0, 1'b0);
        b = 0;
        while (shift_total != s0 + 9 && b < 200) begin
            @(negedge clk);
            b++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_ready", {63'd0, wready}, 64'd0);
        check("abort_shift_en", {63'd0, sen}, 64'd0);
        check("abort_shifts", 64'(shift_total - s0), 64'd10);
        ref_chain = {w0[9:0], ref_chain[39:10]};
        repeat (5) @(negedge clk);
        check("abort_no_done", 64'(done_total - d0), 64'd0);
        check("abort_chain", 64'(chain), 64'(ref_chain));
        do_load($urandom, $urandom, 0, 1'b0);

        repeat (6) do_load($urandom, $urandom, $urandom_range(0, 3), 1'b0);

        small_load($urandom);
        small_load($urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
